// File: rtl/bus_arbiter4_pkg.sv
// Shared encodings and widths for the 4-way round-robin bus arbiter.
package bus_arbiter4_pkg;

  localparam int REQ_W  = 4;
  localparam int DATA_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  function automatic logic [REQ_W-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational rotating-priority picker: first set Req scanning from Prio upward, mod 4.
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [REQ_W-1:0] Req,
  input  logic [1:0]       Prio,
  output logic [1:0]       Win,
  output logic             Any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    Win   = Prio;
    Any   = |Req;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < REQ_W; i++) begin
      idx = Prio + 2'(i);
      if (!found && Req[idx]) begin
        Win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin burst arbiter driving a 4:1 16-bit bus mux; grant lands 1 cycle after request.
// BusReady low stalls the current beat (count, Sel and data held); release always costs one idle cycle.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REQ_W-1:0]  Req,
  input  logic [REQ_W-1:0]  Last,
  input  logic [DATA_W-1:0] Input1,
  input  logic [DATA_W-1:0] Input2,
  input  logic [DATA_W-1:0] Input3,
  input  logic [DATA_W-1:0] Input4,
  input  logic              BusReady,
  output logic [REQ_W-1:0]  Grant,
  output logic [1:0]        Sel,
  output logic              BusValid,
  output logic [DATA_W-1:0] BusData,
  output logic              Busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [REQ_W-1:0] grant_q, grant_d;
  logic [1:0]       sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       prio_q,  prio_d;

  logic       pick_any;
  logic [1:0] pick_win;
  logic       beat;
  logic       release_now;

  rr_pick4 u_pick (
    .Req  (Req),
    .Prio (prio_q),
    .Win  (pick_win),
    .Any  (pick_any)
  );

  assign BusValid = busy_q & Req[sel_q];
  assign beat     = BusValid & BusReady;
  assign Grant    = grant_q;
  assign Sel      = sel_q;
  assign Busy     = busy_q;

  always_comb begin
    case (sel_q)
      2'd0:    BusData = Input1;
      2'd1:    BusData = Input2;
      2'd2:    BusData = Input3;
      default: BusData = Input4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    release_now = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_OWN;
          grant_d = onehot4(pick_win);
          sel_d   = pick_win;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ARB_OWN: begin
        // A withdrawn owner presents no beat, so its Last flag is irrelevant.
        if (!Req[sel_q]) begin
          release_now = 1'b1;
        end else if (beat) begin
          if (Last[sel_q] || (cnt_q == CNT_MAX)) begin
            release_now = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (release_now) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          prio_d  = sel_q + 2'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  a_grant_onehot0: assert property (@(posedge Clk) disable iff (Rst) $onehot0(grant_q));
  a_grant_busy:    assert property (@(posedge Clk) disable iff (Rst) ((grant_q != '0) == busy_q));
  a_grant_sel:     assert property (@(posedge Clk) disable iff (Rst) busy_q |-> (grant_q == onehot4(sel_q)));

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: per-cycle vector table plus multi-cycle burst sequences.
module tb_bus_arbiter4;

  logic        Clk;
  logic        Rst;
  logic [3:0]  Req;
  logic [3:0]  Last;
  logic [15:0] Input1, Input2, Input3, Input4;
  logic        BusReady;
  logic [3:0]  Grant;
  logic [1:0]  Sel;
  logic        BusValid;
  logic [15:0] BusData;
  logic        Busy;

  int total;
  int bad;

  bus_arbiter4 #(.MAX_BURST(8), .CNT_W(3)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req      (Req),
    .Last     (Last),
    .Input1   (Input1),
    .Input2   (Input2),
    .Input3   (Input3),
    .Input4   (Input4),
    .BusReady (BusReady),
    .Grant    (Grant),
    .Sel      (Sel),
    .BusValid (BusValid),
    .BusData  (BusData),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic        rdy;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        b;
    logic        v;
    logic [15:0] d;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] last, logic rdy,
                              logic [3:0] g, logic [1:0] s, logic b, logic v, logic [15:0] d);
    vec_t r;
    r.rst = rst; r.req = req; r.last = last; r.rdy = rdy;
    r.g = g; r.s = s; r.b = b; r.v = v; r.d = d;
    return r;
  endfunction

  function automatic logic [15:0] exp_in(logic [1:0] s);
    case (s)
      2'd0:    return 16'h1111;
      2'd1:    return 16'h2222;
      2'd2:    return 16'hBEEF;
      default: return 16'h4444;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int owners[$];
    int beats_l[$];
    int gaps_l[$];
    int cur_beats;
    int gap;
    int n;
    logic prev_busy;
    logic seen;

    total = 0;
    bad   = 0;
    Input1 = 16'h1111;
    Input2 = 16'h2222;
    Input3 = 16'hBEEF;
    Input4 = 16'h4444;
    Rst = 1'b1; Req = 4'hF; Last = 4'h0; BusReady = 1'b1;

    //            rst req    last   rdy   grant  sel  busy v     data
    tbl[0]  = mk(1, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 0, 16'h1111);
    tbl[1]  = mk(0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 0, 16'h1111);
    tbl[2]  = mk(0, 4'h4, 4'h0, 1, 4'h0, 2'd0, 0, 0, 16'h1111);
    tbl[3]  = mk(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 1, 1, 16'hBEEF);
    tbl[4]  = mk(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 1, 1, 16'hBEEF);
    tbl[5]  = mk(0, 4'h4, 4'h4, 1, 4'h4, 2'd2, 1, 1, 16'hBEEF);
    tbl[6]  = mk(0, 4'hF, 4'h0, 1, 4'h0, 2'd2, 0, 0, 16'hBEEF);
    tbl[7]  = mk(0, 4'hF, 4'h0, 1, 4'h8, 2'd3, 1, 1, 16'h4444);
    tbl[8]  = mk(0, 4'h7, 4'h0, 1, 4'h8, 2'd3, 1, 0, 16'h4444);
    tbl[9]  = mk(0, 4'h5, 4'h0, 1, 4'h0, 2'd3, 0, 0, 16'h4444);
    tbl[10] = mk(0, 4'h5, 4'h0, 1, 4'h1, 2'd0, 1, 1, 16'h1111);
    tbl[11] = mk(0, 4'h5, 4'h0, 1, 4'h1, 2'd0, 1, 1, 16'h1111);
    tbl[12] = mk(0, 4'h4, 4'h0, 1, 4'h1, 2'd0, 1, 0, 16'h1111);
    tbl[13] = mk(0, 4'h4, 4'h0, 1, 4'h0, 2'd0, 0, 0, 16'h1111);
    tbl[14] = mk(0, 4'h4, 4'h4, 1, 4'h4, 2'd2, 1, 1, 16'hBEEF);
    tbl[15] = mk(0, 4'h0, 4'h0, 1, 4'h0, 2'd2, 0, 0, 16'hBEEF);

    // One reset edge so the first table row sees defined registers.
    tick();
    for (int i = 0; i < 16; i++) begin
      Rst = tbl[i].rst; Req = tbl[i].req; Last = tbl[i].last; BusReady = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d grant", i), 32'(Grant),    32'(tbl[i].g));
      chk($sformatf("vec%0d sel", i),   32'(Sel),      32'(tbl[i].s));
      chk($sformatf("vec%0d busy", i),  32'(Busy),     32'(tbl[i].b));
      chk($sformatf("vec%0d valid", i), 32'(BusValid), 32'(tbl[i].v));
      chk($sformatf("vec%0d data", i),  32'(BusData),  32'(tbl[i].d));
      tick();
    end

    // Full-request round robin: five 8-beat tenures in order 0,1,2,3,0.
    reset_dut();
    Req = 4'hF; Last = 4'h0; BusReady = 1'b1;
    prev_busy = 1'b0; seen = 1'b0; cur_beats = 0; gap = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (Busy && !prev_busy) begin
        owners.push_back(int'(Sel));
        cur_beats = 0;
        if (seen) gaps_l.push_back(gap);
      end
      if (!Busy && prev_busy) begin
        beats_l.push_back(cur_beats);
        gap  = 1;
        seen = 1'b1;
      end else if (!Busy) begin
        gap++;
      end
      if (Busy && BusValid && BusReady) begin
        cur_beats++;
        chk("rr beat data", 32'(BusData), 32'(exp_in(Sel)));
      end
      prev_busy = Busy;
      if (beats_l.size() == 5) break;
      tick();
    end
    chk("rr tenure count", 32'(beats_l.size()), 32'd5);
    for (int i = 0; i < owners.size() && i < 5; i++)
      chk($sformatf("rr owner%0d", i), 32'(owners[i]), 32'(i % 4));
    for (int i = 0; i < beats_l.size(); i++)
      chk($sformatf("rr beats%0d", i), 32'(beats_l[i]), 32'd8);
    for (int i = 0; i < gaps_l.size(); i++)
      chk($sformatf("rr gap%0d", i), 32'(gaps_l[i]), 32'd1);

    // Owner 1 stalled for 4 cycles mid-burst; Last during a stall must not release.
    reset_dut();
    Req = 4'b0010; Last = 4'h0; BusReady = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp pre beat%0d valid", i), 32'(BusValid), 32'd1);
      tick();
    end
    BusReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Last = (i == 3) ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("bp stall%0d busy", i), 32'(Busy),    32'd1);
      chk($sformatf("bp stall%0d sel", i),  32'(Sel),     32'd1);
      chk($sformatf("bp stall%0d data", i), 32'(BusData), 32'h2222);
      tick();
    end
    Last = 4'h0; BusReady = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (!Busy) break;
      if (BusValid && BusReady) n++;
      tick();
    end
    chk("bp total beats", 32'(3 + n), 32'd8);

    // Reset while owner 3 is at count 5, with Prio previously moved to 2.
    reset_dut();
    Req = 4'b0010; Last = 4'b0010; BusReady = 1'b1;
    tick();
    tick();
    Req = 4'b1000; Last = 4'h0;
    #1;
    chk("rst pre idle busy", 32'(Busy), 32'd0);
    tick();
    chk("rst owner3 grant", 32'(Grant), 32'h8);
    for (int i = 0; i < 5; i++) tick();
    Rst = 1'b1;
    #1;
    chk("rst owner3 still busy", 32'(Busy), 32'd1);
    tick();
    Rst = 1'b0; Req = 4'b1001;
    #1;
    chk("rst grant",  32'(Grant),    32'h0);
    chk("rst busy",   32'(Busy),     32'd0);
    chk("rst valid",  32'(BusValid), 32'd0);
    chk("rst sel",    32'(Sel),      32'd0);
    chk("rst data",   32'(BusData),  32'h1111);
    tick();
    chk("post rst grant", 32'(Grant), 32'h1);
    chk("post rst sel",   32'(Sel),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
